rand_roller: RTL and testbench
==============================

// Module: rand_roller
// PURPOSE
//   Parametrised dice-style random roller for the lab board: i_start launches a roll that animates
//   o_random_out with progressively slower updates, then settles and logs the result.
//   Results go to a HIST_DEPTH-entry circular history that i_prev/i_next browse while idle.
//   Sits between the debounced key inputs and the 7-segment decoder.
// PARAMETERS
//   DATA_W      4   output/result width; LCG arithmetic is mod 2**DATA_W (DATA_W >= 2)
//   HIST_DEPTH  4   history entries, power of two, >= 2
//   NUM_STEPS   16  value updates per roll
//   BASE_INT    2   cycles from roll start to first update
//   INT_INC     1   extra cycles added to each successive update interval
//   LCG_C       9   LCG additive constant (low DATA_W bits used)
//   FR_W        32  free-running seed counter width (>= 2*DATA_W)
//   LFSR_TAPS   4'b1001  Galois tap mask, DATA_W wide; used only with RAND_ROLLER_LFSR_EN
// PORTS
//   i_clk         in   1                   clock, all logic on rising edge
//   i_rst_n       in   1                   reset, synchronous and active-low
//   i_start       in   1                   one-cycle pulse: start roll / abort running roll
//   i_prev        in   1                   one-cycle pulse: view older history entry
//   i_next        in   1                   one-cycle pulse: view newer history entry
//   o_random_out  out  DATA_W              live value while rolling, else viewed history entry
//   o_busy        out  1                   1 while in S_ROLL
//   o_done        out  1                   one-cycle pulse when a result is logged
//   o_hist_ofs    out  $clog2(HIST_DEPTH)  view offset, 0 = newest
// BEHAVIOUR
//   Reset (i_rst_n low at an edge): state S_IDLE, FR=0, x=0, history cleared, count=0, ofs=0;
//     o_random_out=0, o_busy=0, o_done=0, o_hist_ofs=0.
//   FR increments by 1 every non-reset cycle and wraps modulo 2**FR_W.
//   S_IDLE and i_start: A = {FR[DATA_W-1:1],1'b1} (always odd); x = FR[2*DATA_W-1:DATA_W];
//     tick=0, step=0; go to S_ROLL. i_start wins over simultaneous i_prev/i_next.
//   S_ROLL: tick increments each cycle. When tick == BASE_INT + step*INT_INC - 1:
//     x <= (x*A + LCG_C) mod 2**DATA_W; step++; tick=0.
//     Updates land BASE_INT, then BASE_INT+INT_INC, ... cycles apart.
//   The edge applying update NUM_STEPS writes the new x to history and goes to S_IDLE;
//     o_done=1 for the following cycle.
//   i_start in S_ROLL aborts: current x is logged immediately (same write/o_done rules), no further update.
//   History write: hist[wr_ptr]=value; wr_ptr wraps modulo HIST_DEPTH; count saturates at
//     HIST_DEPTH (oldest entry is overwritten); ofs resets to 0.
//   Browse (S_IDLE only): i_prev raises ofs if ofs < count-1; i_next lowers ofs if ofs > 0.
//     Both pulses together: no change. Pulses in S_ROLL or with count==0 are ignored.
//   o_random_out = x in S_ROLL; in S_IDLE it is hist[wr_ptr-1-ofs] mod HIST_DEPTH, or 0 when count==0.
//   Every output is registered. Intervals use widths wide enough that there is no overflow for the
//     given parameters. Reset mid-roll is a plain reset: nothing is logged.
// CONFIGURATION
//   RAND_ROLLER_LFSR_EN defined: the update becomes a Galois LFSR step,
//     x <= (x>>1) ^ (x[0] ? LFSR_TAPS : 0); start seed x = FR[DATA_W-1:0] | 1 (never zero); A unused.
//   Not defined: the LCG update above; LFSR_TAPS is ignored.
// STRUCTURE
//   rand_roller_pkg: state_t enum {S_IDLE,S_ROLL}; function lcg_next(x,a,c); function lfsr_next(x,taps).
//   Sub-module rand_hist_buf: circular store, wr_ptr, count, ofs browse logic and read mux.
//   rand_roller keeps the FSM, FR, the interval counters and the generator.
// TESTING (DATA_W=4, BASE_INT=2, INT_INC=1, NUM_STEPS=3, LCG_C=9)
//   1 Start sampled when FR==5 (A=5, x=0) -> o_random_out 9 at +2, 6 at +5, 7 at +9;
//     o_done one cycle; history[0]=7; o_busy falls.
//   2 Abort: start at FR==5, second start at +3 -> logged 9, no further updates, o_done pulses.
//   3 Five rolls with HIST_DEPTH=4 -> count stays 4; i_prev x5 stops at ofs=3 on the second-roll
//     result; i_next x4 stops at ofs=0.
//   4 Prev/next while count==0 or during S_ROLL -> ofs and o_random_out unchanged;
//     start+prev in the same cycle -> roll starts, ofs stays 0.
//   5 i_rst_n low mid-roll for one edge -> all outputs 0, count 0, no o_done.
//   6 RAND_ROLLER_LFSR_EN, start at FR==5 -> x0=5, then 11, 12, 6.

Source files
------------

// File: rtl/rand_roller_pkg.sv
// rand_roller_pkg
//   Shared types and helpers for the dice-style random roller.
//   state_t   : roller FSM states (S_IDLE, S_ROLL)
//   lcg_next  : one linear congruential step, x*a + c (caller keeps the low bits it needs)
//   lfsr_next : one Galois LFSR step, (x >> 1) ^ (x[0] ? taps : 0)
//   Both helpers work on 32-bit values so that any DATA_W up to 32 can use them;
//   callers zero-extend their operands and truncate the result back to DATA_W.
package rand_roller_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ROLL = 1'b1
  } state_t;

  function automatic logic [31:0] lcg_next(input logic [31:0] x,
                                           input logic [31:0] a,
                                           input logic [31:0] c);
    return x * a + c;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] x,
                                            input logic [31:0] taps);
    return (x >> 1) ^ (x[0] ? taps : 32'd0);
  endfunction

endpackage

// File: rtl/rand_hist_buf.sv
// rand_hist_buf
//   Circular result history for rand_roller with browse logic.
//   Ports:
//     i_clk, i_rst_n : clock and synchronous active-low reset
//     i_wr_en        : log i_wr_data this cycle (newest entry), view offset returns to 0
//     i_wr_data      : value to log
//     i_browse_en    : browse pulses are honoured this cycle (idle, no start)
//     i_prev, i_next : step the view offset older / newer
//     o_ofs          : registered view offset, 0 = newest
//     o_view_d       : entry that will be on view after this edge (0 when empty);
//                      the parent registers it into its output flop
module rand_hist_buf
  import rand_roller_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int HIST_DEPTH = 4,
  localparam int OFS_W     = $clog2(HIST_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_browse_en,
  input  logic              i_prev,
  input  logic              i_next,
  output logic [OFS_W-1:0]  o_ofs,
  output logic [DATA_W-1:0] o_view_d
);

  localparam int CNT_W = $clog2(HIST_DEPTH + 1);

  logic [DATA_W-1:0] hist_q [HIST_DEPTH];
  logic [OFS_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [OFS_W-1:0]  ofs_q, ofs_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OFS_W-1:0]  rd_idx;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    ofs_d    = ofs_q;
    if (i_wr_en) begin
      // HIST_DEPTH is a power of two, so the pointer wraps on its own.
      wr_ptr_d = wr_ptr_q + OFS_W'(1);
      if (cnt_q != CNT_W'(HIST_DEPTH)) cnt_d = cnt_q + CNT_W'(1);
      ofs_d = '0;
    end else if (i_browse_en && (cnt_q != '0)) begin
      if (i_prev && !i_next && (CNT_W'(ofs_q) < cnt_q - CNT_W'(1))) begin
        ofs_d = ofs_q + OFS_W'(1);
      end else if (i_next && !i_prev && (ofs_q != '0)) begin
        ofs_d = ofs_q - OFS_W'(1);
      end
    end
  end

  // View of the post-edge state. On a write the offset snaps to 0 and the
  // newest entry is the one being written, so forward it instead of reading
  // the array slot that has not been updated yet.
  always_comb begin
    rd_idx = wr_ptr_d - OFS_W'(1) - ofs_d;
    if (cnt_d == '0) begin
      o_view_d = '0;
    end else if (i_wr_en) begin
      o_view_d = i_wr_data;
    end else begin
      o_view_d = hist_q[rd_idx];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      ofs_q    <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      ofs_q    <= ofs_d;
      if (i_wr_en) hist_q[wr_ptr_q] <= i_wr_data;
    end
  end

  assign o_ofs = ofs_q;

endmodule

// File: rtl/rand_roller.sv
// rand_roller
//   Dice-style roller: i_start launches a roll whose value updates NUM_STEPS
//   times at progressively longer intervals, then the result is logged into a
//   circular history that i_prev / i_next browse while idle.
//   Ports:
//     i_clk, i_rst_n : clock and synchronous active-low reset
//     i_start        : start a roll (idle) / abort and log the running roll
//     i_prev, i_next : browse older / newer history entries (idle only)
//     o_random_out   : live value while rolling, else the viewed history entry
//     o_busy         : high while rolling
//     o_done         : one-cycle pulse after a result is logged
//     o_hist_ofs     : history view offset, 0 = newest
//   Build option: define RAND_ROLLER_LFSR_EN to replace the LCG update with a
//   Galois LFSR step (seed = FR[DATA_W-1:0] | 1, multiplier unused).
module rand_roller
  import rand_roller_pkg::*;
#(
  parameter int              DATA_W     = 4,
  parameter int              HIST_DEPTH = 4,
  parameter int              NUM_STEPS  = 16,
  parameter int              BASE_INT   = 2,
  parameter int              INT_INC    = 1,
  parameter int              LCG_C      = 9,
  parameter int              FR_W       = 32,
  parameter logic [DATA_W-1:0] LFSR_TAPS = 4'b1001
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic                          i_prev,
  input  logic                          i_next,
  output logic [DATA_W-1:0]             o_random_out,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [$clog2(HIST_DEPTH)-1:0] o_hist_ofs
);

`ifdef RAND_ROLLER_LFSR_EN
  localparam bit LFSR_MODE = 1'b1;
`else
  localparam bit LFSR_MODE = 1'b0;
`endif

  // Longest interval is BASE_INT + (NUM_STEPS-1)*INT_INC; tick never exceeds it.
  localparam int TICK_W = $clog2(BASE_INT + (NUM_STEPS - 1) * INT_INC + 1);
  localparam int STEP_W = $clog2(NUM_STEPS + 1);

  state_t            state_q, state_d;
  logic [FR_W-1:0]   fr_q;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              log_en;
  logic [31:0]       limit;
  logic [31:0]       lcg_full, lfsr_full;
  logic [DATA_W-1:0] gen_next;
  logic [DATA_W-1:0] view_d;
  logic [DATA_W-1:0] random_out_q;
  logic              busy_q, done_q;

  always_comb begin
    lcg_full  = lcg_next(32'(x_q), 32'(a_q), 32'(LCG_C));
    lfsr_full = lfsr_next(32'(x_q), 32'(LFSR_TAPS));
    gen_next  = LFSR_MODE ? DATA_W'(lfsr_full) : DATA_W'(lcg_full);
    // Update k (k = step) fires when tick reaches its interval minus one.
    limit     = 32'(BASE_INT) + 32'(step_q) * 32'(INT_INC) - 32'd1;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    a_d     = a_q;
    tick_d  = tick_q;
    step_d  = step_q;
    log_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (LFSR_MODE) begin
            x_d = fr_q[DATA_W-1:0] | DATA_W'(1);   // LFSR must never hold zero
          end else begin
            x_d = fr_q[2*DATA_W-1:DATA_W];
          end
          a_d     = {fr_q[DATA_W-1:1], 1'b1};      // odd multiplier
          tick_d  = '0;
          step_d  = '0;
          state_d = S_ROLL;
        end
      end
      S_ROLL: begin
        if (i_start) begin
          // Abort: log the value currently showing, even on an update edge.
          log_en  = 1'b1;
          state_d = S_IDLE;
        end else if (32'(tick_q) == limit) begin
          x_d    = gen_next;
          step_d = step_q + STEP_W'(1);
          tick_d = '0;
          if (32'(step_q) == 32'(NUM_STEPS - 1)) begin
            log_en  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  rand_hist_buf #(
    .DATA_W     (DATA_W),
    .HIST_DEPTH (HIST_DEPTH)
  ) u_hist (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_wr_en     (log_en),
    .i_wr_data   (x_d),
    .i_browse_en ((state_q == S_IDLE) && !i_start),
    .i_prev      (i_prev),
    .i_next      (i_next),
    .o_ofs       (o_hist_ofs),
    .o_view_d    (view_d)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      fr_q         <= '0;
      x_q          <= '0;
      a_q          <= '0;
      tick_q       <= '0;
      step_q       <= '0;
      random_out_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fr_q         <= fr_q + FR_W'(1);
      x_q          <= x_d;
      a_q          <= a_d;
      tick_q       <= tick_d;
      step_q       <= step_d;
      random_out_q <= (state_d == S_ROLL) ? x_d : view_d;
      busy_q       <= (state_d == S_ROLL);
      done_q       <= log_en;
    end
  end

  assign o_random_out = random_out_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule

// File: tb/tb_rand_roller.sv
// tb_rand_roller
//   Directed bench for rand_roller (DATA_W=4, HIST_DEPTH=4, NUM_STEPS=3,
//   BASE_INT=2, INT_INC=1, LCG_C=9). A behavioural model computes the roll
//   sequence up front and derives update times from the closed-form interval
//   sum; a negedge process compares every output each cycle, and literal
//   values pin the model on the hand-worked roll started at FR==5.
module tb_rand_roller;

  localparam int NS = 3;
  localparam int BI = 2;
  localparam int II = 1;
  localparam int LC = 9;
  localparam int HD = 4;

`ifdef RAND_ROLLER_LFSR_EN
  localparam int EXP1 [4] = '{5, 11, 12, 6};
`else
  localparam int EXP1 [4] = '{0, 9, 6, 7};
`endif

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic       i_prev = 1'b0;
  logic       i_next = 1'b0;
  logic [3:0] o_random_out;
  logic       o_busy;
  logic       o_done;
  logic [1:0] o_hist_ofs;

  always #5 i_clk = ~i_clk;

  rand_roller #(
    .DATA_W     (4),
    .HIST_DEPTH (HD),
    .NUM_STEPS  (NS),
    .BASE_INT   (BI),
    .INT_INC    (II),
    .LCG_C      (LC),
    .FR_W       (32),
    .LFSR_TAPS  (4'b1001)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_prev       (i_prev),
    .i_next       (i_next),
    .o_random_out (o_random_out),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_hist_ofs   (o_hist_ofs)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  int unsigned m_fr = 0;
  bit          m_valid = 1'b0;
  bit          m_roll = 1'b0;
  bit          m_done = 1'b0;
  int          m_rel = 0;
  int          m_ofs = 0;
  int          m_seq [0:NS];
  int          m_hist [$];
  int          m_log [$];

  // Cycles from roll start until update j has landed.
  function automatic int cum(input int j);
    return j * BI + II * j * (j - 1) / 2;
  endfunction

  function automatic int n_upd(input int rel);
    int k = 0;
    for (int j = 1; j <= NS; j++) if (cum(j) <= rel) k = j;
    return k;
  endfunction

  function automatic void seed(input int unsigned fr);
    int lo;
    int hi;
    lo = int'(fr % 32'd16);
    hi = int'((fr / 32'd16) % 32'd16);
`ifdef RAND_ROLLER_LFSR_EN
    m_seq[0] = lo | 1;
    for (int i = 1; i <= NS; i++)
      m_seq[i] = (m_seq[i-1] / 2) ^ (((m_seq[i-1] % 2) == 1) ? 9 : 0);
`else
    m_seq[0] = hi;
    for (int i = 1; i <= NS; i++)
      m_seq[i] = (m_seq[i-1] * (lo | 1) + LC) % 16;
`endif
  endfunction

  function automatic void log_val(input int v);
    m_hist.push_back(v);
    if (m_hist.size() > HD) void'(m_hist.pop_front());
    m_log.push_back(v);
    m_ofs  = 0;
    m_done = 1'b1;
    m_roll = 1'b0;
  endfunction

  function automatic int exp_out();
    if (m_roll) return m_seq[n_upd(m_rel)];
    if (m_hist.size() == 0) return 0;
    return m_hist[m_hist.size() - 1 - m_ofs];
  endfunction

  always @(posedge i_clk) begin
    if (!i_rst_n) begin
      m_fr = 0; m_roll = 1'b0; m_rel = 0; m_ofs = 0; m_done = 1'b0;
      m_hist.delete(); m_log.delete();
      m_valid = 1'b1;
    end else begin
      m_done = 1'b0;
      if (m_roll) begin
        if (i_start) log_val(m_seq[n_upd(m_rel)]);
        else begin
          m_rel++;
          if (n_upd(m_rel) == NS) log_val(m_seq[NS]);
        end
      end else if (i_start) begin
        seed(m_fr);
        m_roll = 1'b1;
        m_rel  = 0;
      end else if (m_hist.size() > 0) begin
        if (i_prev && !i_next && m_ofs < m_hist.size() - 1) m_ofs++;
        else if (i_next && !i_prev && m_ofs > 0) m_ofs--;
      end
      m_fr++;
    end
  end

  always @(negedge i_clk) begin
    if (m_valid) begin
      chk("out",  int'(o_random_out), exp_out());
      chk("busy", int'(o_busy), int'(m_roll));
      chk("done", int'(o_done), int'(m_done));
      chk("ofs",  int'(o_hist_ofs), m_ofs);
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse(input bit s, input bit p, input bit n);
    i_start = s; i_prev = p; i_next = n;
    @(negedge i_clk);
    i_start = 1'b0; i_prev = 1'b0; i_next = 1'b0;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic wait_fr(input int unsigned v);
    int n = 0;
    while (m_fr != v && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    chk("wait_fr", int'(m_fr == v), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_busy && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    chk("roll_end", int'(o_busy), 0);
  endtask

  initial begin
    repeat (3) @(negedge i_clk);
    chk("rst_out", int'(o_random_out), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_ofs", int'(o_hist_ofs), 0);
    i_rst_n = 1'b1;

    // 1 / 6: full roll started with FR==5
    wait_fr(5);
    pulse(1, 0, 0);
    $display("t1 roll started at FR 5");
    chk("t1_busy", int'(o_busy), 1);
    chk("t1_x0", int'(o_random_out), EXP1[0]);
    repeat (2) @(negedge i_clk);
    chk("t1_u1", int'(o_random_out), EXP1[1]);
    repeat (3) @(negedge i_clk);
    chk("t1_u2", int'(o_random_out), EXP1[2]);
    repeat (3) @(negedge i_clk);
    chk("t1_pre_u3_busy", int'(o_busy), 1);
    @(negedge i_clk);
    chk("t1_u3", int'(o_random_out), EXP1[3]);
    chk("t1_done", int'(o_done), 1);
    chk("t1_busy_fall", int'(o_busy), 0);
    @(negedge i_clk);
    chk("t1_done_once", int'(o_done), 0);
    chk("t1_hist0", int'(o_random_out), EXP1[3]);
    $display("t1 roll logged %0d", o_random_out);

    // 2: abort after the first update
    do_reset();
    wait_fr(5);
    pulse(1, 0, 0);
    repeat (2) @(negedge i_clk);
    chk("t2_u1", int'(o_random_out), EXP1[1]);
    pulse(1, 0, 0);
    chk("t2_done", int'(o_done), 1);
    chk("t2_busy", int'(o_busy), 0);
    chk("t2_logged", int'(o_random_out), EXP1[1]);
    repeat (6) @(negedge i_clk);
    chk("t2_hold", int'(o_random_out), EXP1[1]);
    $display("t2 abort logged %0d", o_random_out);

    // 4a: browse with empty history
    do_reset();
    pulse(0, 1, 0);
    chk("t4_empty_prev_ofs", int'(o_hist_ofs), 0);
    chk("t4_empty_prev_out", int'(o_random_out), 0);
    pulse(0, 0, 1);
    chk("t4_empty_next_ofs", int'(o_hist_ofs), 0);
    $display("t4 empty-history browse done");

    // 3: five rolls into four entries, then browse to both ends
    for (int r = 0; r < 5; r++) begin
      repeat (r + 1) @(negedge i_clk);
      pulse(1, 0, 0);
      wait_idle();
      @(negedge i_clk);
      $display("t3 roll %0d logged %0d", r, o_random_out);
    end
    for (int i = 0; i < 5; i++) pulse(0, 1, 0);
    chk("t3_ofs_max", int'(o_hist_ofs), 3);
    chk("t3_oldest", int'(o_random_out), m_log[1]);
    pulse(0, 1, 1);
    chk("t3_both", int'(o_hist_ofs), 3);
    for (int i = 0; i < 4; i++) pulse(0, 0, 1);
    chk("t3_ofs_min", int'(o_hist_ofs), 0);
    chk("t3_newest", int'(o_random_out), m_log[4]);

    // 4b: browse ignored while rolling; start wins over prev
    pulse(0, 1, 0);
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    pulse(0, 0, 1);
    chk("t4_roll_ofs", int'(o_hist_ofs), 1);
    chk("t4_roll_busy", int'(o_busy), 1);
    wait_idle();
    @(negedge i_clk);
    chk("t4_after_ofs", int'(o_hist_ofs), 0);
    pulse(1, 1, 0);
    chk("t4_start_prev_busy", int'(o_busy), 1);
    chk("t4_start_prev_ofs", int'(o_hist_ofs), 0);
    wait_idle();
    $display("t4 roll-time browse done");

    // 5: reset mid-roll
    repeat (2) @(negedge i_clk);
    pulse(1, 0, 0);
    repeat (3) @(negedge i_clk);
    do_reset();
    chk("t5_out", int'(o_random_out), 0);
    chk("t5_busy", int'(o_busy), 0);
    chk("t5_done", int'(o_done), 0);
    @(negedge i_clk);
    chk("t5_no_done", int'(o_done), 0);
    pulse(0, 1, 0);
    chk("t5_count0", int'(o_hist_ofs), 0);
    chk("t5_count0_out", int'(o_random_out), 0);
    $display("t5 mid-roll reset done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
